cpu_sequencer: RTL and testbench

- M-cycle sequencer for the SM83-style core; drives the combinational opcode/step decoder and owns the instruction register (IR) and the step counter.
- Consumes the decoder's done/is_cond/next_cond outputs, the flags and the memory-ready handshake, and produces the opcode/step pair presented to the decoder each M-cycle.
- Handles the boot fetch, wait-state stalls, conditional-branch step redirects, interrupt injection at instruction boundaries, and a lock-up trap for runaway microcode.

---
 rtl/cpu_sequencer.sv | 112 +++++++++++
 tb/tb_cpu_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// M-cycle sequencer for the SM83-style core: owns IR and step counter, drives the
// opcode/step pair into the decoder, and handles boot fetch, stalls, cc redirects, IRQ injection and lock-up.
module cpu_sequencer #(
  parameter logic [7:0] INT_OPCODE = 8'hD3,
  parameter logic [2:0] MAX_STEP   = 3'd7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ready,
  input  logic [7:0]  mem_rdata,
  input  logic [3:0]  flags,
  input  logic        dec_done,
  input  logic        dec_is_cond,
  input  logic [2:0]  dec_next_cond,
  input  logic        int_req,
  input  logic        ime,
  output logic [7:0]  opcode,
  output logic [2:0]  step,
  output logic        boot_fetch,
  output logic        cycle_en,
  output logic        int_ack,
  output logic        locked,
  output logic [15:0] m_cycles
);

  localparam int unsigned OP_W  = 8;
  localparam int unsigned STP_W = 3;
  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_LOCK = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [OP_W-1:0]  opcode_nxt;
  logic [STP_W-1:0] step_nxt;
  logic             locked_nxt;
  logic [CNT_W-1:0] m_cycles_nxt;
  logic             cc_true;

  // N and H play no part in branch conditions
  logic unused_flags;
  assign unused_flags = ^flags[2:1];

  // Branch condition from opcode[4:3] against the flags of the committing cycle
  always_comb begin
    cc_true = 1'b0;
    case (opcode[4:3])
      2'd0:    cc_true = ~flags[3];
      2'd1:    cc_true = flags[3];
      2'd2:    cc_true = ~flags[0];
      default: cc_true = flags[0];
    endcase
  end

  // Next-state and strobe logic
  always_comb begin
    state_nxt    = state;
    opcode_nxt   = opcode;
    step_nxt     = step;
    locked_nxt   = locked;
    int_ack      = 1'b0;
    boot_fetch   = (state == S_BOOT);
    cycle_en     = mem_ready & (state != S_LOCK);
    m_cycles_nxt = m_cycles + CNT_W'(cycle_en);

    if (cycle_en) begin
      case (state)
        S_BOOT: begin
          opcode_nxt = mem_rdata;
          step_nxt   = '0;
          state_nxt  = S_RUN;
        end
        S_RUN: begin
          if (dec_done && int_req && ime) begin
            opcode_nxt = INT_OPCODE;
            step_nxt   = '0;
            int_ack    = 1'b1;
          end else if (dec_done) begin
            opcode_nxt = mem_rdata;
            step_nxt   = '0;
          end else if (dec_is_cond) begin
            step_nxt = cc_true ? STP_W'(step + STP_W'(1)) : dec_next_cond;
          end else if (step == MAX_STEP) begin
            state_nxt  = S_LOCK;
            locked_nxt = 1'b1;
          end else begin
            step_nxt = STP_W'(step + STP_W'(1));
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_BOOT;
      opcode   <= '0;
      step     <= '0;
      locked   <= 1'b0;
      m_cycles <= '0;
    end else begin
      state    <= state_nxt;
      opcode   <= opcode_nxt;
      step     <= step_nxt;
      locked   <= locked_nxt;
      m_cycles <= m_cycles_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed testbench for cpu_sequencer: boot, wait states, cc redirects, IRQ injection, lock-up, async reset.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_ready;
  logic [7:0]  mem_rdata;
  logic [3:0]  flags;
  logic        dec_done;
  logic        dec_is_cond;
  logic [2:0]  dec_next_cond;
  logic        int_req;
  logic        ime;
  logic [7:0]  opcode;
  logic [2:0]  step;
  logic        boot_fetch;
  logic        cycle_en;
  logic        int_ack;
  logic        locked;
  logic [15:0] m_cycles;

  int tests = 0;
  int fails = 0;

  cpu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .flags(flags), .dec_done(dec_done), .dec_is_cond(dec_is_cond),
    .dec_next_cond(dec_next_cond), .int_req(int_req), .ime(ime),
    .opcode(opcode), .step(step), .boot_fetch(boot_fetch), .cycle_en(cycle_en),
    .int_ack(int_ack), .locked(locked), .m_cycles(m_cycles)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dec_done = 1'b0; dec_is_cond = 1'b0; dec_next_cond = 3'd0;
    int_req = 1'b0; ime = 1'b0; flags = 4'b0000;
  endtask

  task automatic test_reset();
    idle_inputs();
    mem_ready = 1'b0; mem_rdata = 8'h3E;
    rst_n = 1'b0;
    #12;
    tests++; if (opcode !== 8'h00) begin fails++; $display("FAIL reset_opcode got %h exp 00", opcode); end
    tests++; if (step !== 3'd0) begin fails++; $display("FAIL reset_step got %0d exp 0", step); end
    tests++; if (m_cycles !== 16'd0) begin fails++; $display("FAIL reset_mcycles got %0d exp 0", m_cycles); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked got %b exp 0", locked); end
    tests++; if (boot_fetch !== 1'b1) begin fails++; $display("FAIL reset_boot_fetch got %b exp 1", boot_fetch); end
    tests++; if (cycle_en !== 1'b0) begin fails++; $display("FAIL reset_cycle_en_nr got %b exp 0", cycle_en); end
    mem_ready = 1'b1;
    #1;
    tests++; if (cycle_en !== 1'b1) begin fails++; $display("FAIL reset_cycle_en_r got %b exp 1", cycle_en); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    tests++; if (boot_fetch !== 1'b0) begin fails++; $display("FAIL boot_fetch_drop got %b exp 0", boot_fetch); end
    tests++; if (opcode !== 8'h3E) begin fails++; $display("FAIL boot_opcode got %h exp 3e", opcode); end
    tests++; if (step !== 3'd0) begin fails++; $display("FAIL boot_step got %0d exp 0", step); end
    tests++; if (m_cycles !== 16'd1) begin fails++; $display("FAIL boot_mcycles got %0d exp 1", m_cycles); end
  endtask

  task automatic test_wait_state();
    tick();
    tests++; if (step !== 3'd1) begin fails++; $display("FAIL ws_step1 got %0d exp 1", step); end
    mem_ready = 1'b0; dec_done = 1'b1; mem_rdata = 8'h28;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (cycle_en !== 1'b0) begin fails++; $display("FAIL ws_cycle_en[%0d] got %b exp 0", i, cycle_en); end
      tick();
      tests++; if (step !== 3'd1 || opcode !== 8'h3E || m_cycles !== 16'd2) begin
        fails++; $display("FAIL ws_hold[%0d] got op=%h step=%0d m=%0d exp op=3e step=1 m=2", i, opcode, step, m_cycles);
      end
    end
    mem_ready = 1'b1;
    tick();
    tests++; if (opcode !== 8'h28 || step !== 3'd0 || m_cycles !== 16'd3) begin
      fails++; $display("FAIL ws_release got op=%h step=%0d m=%0d exp op=28 step=0 m=3", opcode, step, m_cycles);
    end
    dec_done = 1'b0;
  endtask

  task automatic test_cond_branch();
    tick();
    dec_is_cond = 1'b1; dec_next_cond = 3'd3; flags = 4'b0000;
    tick();
    tests++; if (step !== 3'd3 || m_cycles !== 16'd5) begin
      fails++; $display("FAIL cond_nz_taken got step=%0d m=%0d exp step=3 m=5", step, m_cycles);
    end
    dec_is_cond = 1'b0; dec_done = 1'b1; mem_rdata = 8'h28;
    tick();
    dec_done = 1'b0;
    tick();
    tests++; if (step !== 3'd1 || opcode !== 8'h28) begin
      fails++; $display("FAIL cond_refetch got op=%h step=%0d exp op=28 step=1", opcode, step);
    end
    dec_is_cond = 1'b1; flags = 4'b1000;
    tick();
    tests++; if (step !== 3'd2 || m_cycles !== 16'd8) begin
      fails++; $display("FAIL cond_z_fallthru got step=%0d m=%0d exp step=2 m=8", step, m_cycles);
    end
    // done together with is_cond: done wins
    dec_done = 1'b1; flags = 4'b0000; mem_rdata = 8'h00;
    tick();
    tests++; if (opcode !== 8'h00 || step !== 3'd0 || m_cycles !== 16'd9) begin
      fails++; $display("FAIL done_beats_cond got op=%h step=%0d m=%0d exp op=00 step=0 m=9", opcode, step, m_cycles);
    end
    dec_done = 1'b0; dec_is_cond = 1'b0; dec_next_cond = 3'd0;
  endtask

  task automatic test_interrupt();
    mem_ready = 1'b0; dec_done = 1'b1; int_req = 1'b1; ime = 1'b1; mem_rdata = 8'h00;
    #1;
    tests++; if (int_ack !== 1'b0) begin fails++; $display("FAIL irq_stall_ack got %b exp 0", int_ack); end
    mem_ready = 1'b1;
    #1;
    tests++; if (int_ack !== 1'b1) begin fails++; $display("FAIL irq_ack got %b exp 1", int_ack); end
    tick();
    tests++; if (opcode !== 8'hD3 || step !== 3'd0 || m_cycles !== 16'd10) begin
      fails++; $display("FAIL irq_inject got op=%h step=%0d m=%0d exp op=d3 step=0 m=10", opcode, step, m_cycles);
    end
    ime = 1'b0;
    #1;
    tests++; if (int_ack !== 1'b0) begin fails++; $display("FAIL irq_ack_ime0 got %b exp 0", int_ack); end
    tick();
    tests++; if (opcode !== 8'h00 || step !== 3'd0 || m_cycles !== 16'd11) begin
      fails++; $display("FAIL irq_masked got op=%h step=%0d m=%0d exp op=00 step=0 m=11", opcode, step, m_cycles);
    end
    idle_inputs();
  endtask

  task automatic test_lock();
    for (int i = 1; i <= 7; i++) tick();
    tests++; if (step !== 3'd7 || locked !== 1'b0 || m_cycles !== 16'd18) begin
      fails++; $display("FAIL lock_pre got step=%0d lk=%b m=%0d exp step=7 lk=0 m=18", step, locked, m_cycles);
    end
    tick();
    tests++; if (locked !== 1'b1 || step !== 3'd7 || opcode !== 8'h00 || m_cycles !== 16'd19) begin
      fails++; $display("FAIL lock_enter got lk=%b step=%0d op=%h m=%0d exp lk=1 step=7 op=00 m=19", locked, step, opcode, m_cycles);
    end
    tests++; if (cycle_en !== 1'b0) begin fails++; $display("FAIL lock_cycle_en got %b exp 0", cycle_en); end
    dec_done = 1'b1; mem_rdata = 8'h55;
    tick(); tick();
    tests++; if (locked !== 1'b1 || opcode !== 8'h00 || m_cycles !== 16'd19) begin
      fails++; $display("FAIL lock_frozen got lk=%b op=%h m=%0d exp lk=1 op=00 m=19", locked, opcode, m_cycles);
    end
    rst_n = 1'b0;
    #1;
    tests++; if (locked !== 1'b0 || boot_fetch !== 1'b1) begin
      fails++; $display("FAIL lock_reset got lk=%b bf=%b exp lk=0 bf=1", locked, boot_fetch);
    end
    idle_inputs();
    mem_rdata = 8'h3E;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    tests++; if (opcode !== 8'h3E || m_cycles !== 16'd1) begin
      fails++; $display("FAIL ar_boot got op=%h m=%0d exp op=3e m=1", opcode, m_cycles);
    end
    tick(); tick();
    tests++; if (step !== 3'd2) begin fails++; $display("FAIL ar_step2 got %0d exp 2", step); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (opcode !== 8'h00 || step !== 3'd0 || m_cycles !== 16'd0 || boot_fetch !== 1'b1) begin
      fails++; $display("FAIL ar_clear got op=%h step=%0d m=%0d bf=%b exp op=00 step=0 m=0 bf=1", opcode, step, m_cycles, boot_fetch);
    end
    tick();
    rst_n = 1'b1; mem_rdata = 8'h06;
    tick();
    tests++; if (opcode !== 8'h06 || step !== 3'd0 || m_cycles !== 16'd1 || boot_fetch !== 1'b0) begin
      fails++; $display("FAIL ar_refetch got op=%h step=%0d m=%0d bf=%b exp op=06 step=0 m=1 bf=0", opcode, step, m_cycles, boot_fetch);
    end
  endtask

  initial begin
    test_reset();
    test_wait_state();
    test_cond_branch();
    test_interrupt();
    test_lock();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
